cdc_f2s_sender: RTL
===================

# cdc_f2s_sender

Fast-domain transmitting end of a fast-to-slow word transfer: the counterpart of the slow-to-fast delay-sampling receiver. Buffers words arriving with a one-cycle enable in the fast clock domain, presents each word on a held-stable bus with a toggle request, and waits for the slow domain's toggle acknowledge, synchronized internally, before presenting the next word. No word may be lost or duplicated regardless of the slow clock's ratio, for example 100 MHz to 20 MHz or 999 kHz.

## Interface
- DW, 32, data width.
- DEPTH, 4, input FIFO depth; power of two, at least 2.
- SYNC_STAGES, 2, flops in the `tx_ack` synchronizer; at least 2.

- clk  in  1  fast-domain clock.
- rst  in  1  reset: synchronous, active-high.
- din  in  DW  input word, sampled when `din_en & din_rdy`.
- din_en  in  1  input word valid, one-cycle qualifier.
- din_rdy  out  1  equals `~full`; combinational from the FIFO count.
- tx_data  out  DW  registered word presented to the slow domain; stable for the entire time `tx_req != ack_s`.
- tx_req  out  1  registered request toggle; each transition announces one new `tx_data`.
- tx_ack  in  1  acknowledge toggle from the slow domain; asynchronous to `clk`.
- tx_done  out  1  one-cycle pulse when a word's acknowledge is seen.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- ovf  out  1  sticky flag; set by `din_en & ~din_rdy` (the word is dropped); cleared only by `rst`.

## Operation
- Synchronizer: a shift chain of SYNC_STAGES flops on `tx_ack`. `ack_s` is the last stage. No other logic reads `tx_ack` directly.
- FIFO: DEPTH entries with wrap-around pointers and a count of width clog2(DEPTH)+1.
  - Push: `din_en & ~full`.
  - Pop: FSM LOAD.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, a push is refused even if a pop occurs that cycle (`din_rdy` depends on count only).
- FSM states IDLE, LOAD, WAIT:
  - IDLE → LOAD when FIFO non-empty.
  - LOAD: pop the head into `tx_data`, toggle `tx_req`, then → WAIT. This is the only state that writes `tx_data` or `tx_req`.
  - WAIT → IDLE when `ack_s == tx_req`. Pulse `tx_done` in the same cycle.
  - In IDLE and LOAD, `ack_s` is ignored.
- Reset values: state IDLE, FIFO empty, `tx_data=0`, `tx_req=0`, `tx_done=0`, `ovf=0`, all synchronizer flops 0. `busy=0` and `din_rdy=1` in the first cycle after reset.
- Reset mid-transfer: all state is discarded, including FIFO contents and any unacknowledged word. The slow-domain receiver must be reset in the same event so that its ack toggle returns to 0.
- Widths: pointers wrap modulo DEPTH; the count never exceeds DEPTH.

## Timing
- Word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - FIFO non-empty in cycle N+1.
  - LOAD at edge N+2; `tx_data` and `tx_req` change after edge N+2.
- Ack toggle arriving at edge A (assumed to meet setup) appears on `ack_s` after edge A+SYNC_STAGES-1. `tx_done` is asserted in the following cycle, and the FSM is back in IDLE one edge later.
- Back-to-back words: minimum spacing between `tx_req` toggles is 3 clk plus the ack round trip. The FIFO absorbs bursts of DEPTH words.
- Handshake rule: `tx_data` must not change while `tx_req != ack_s`. The slow side samples `tx_data` after it synchronizes `tx_req`.

## Structure
- Shared header `cdc_defs.vh`: FSM state encodings (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2) and the default synchronizer depth.
- One sub-module: `sync_fifo` (parameters DW, DEPTH; ports clk, rst, push, din, pop, dout, full, empty, count).
- The synchronizer and FSM are inline, at roughly 200 lines of RTL total.

## Test plan
- Single word, din=32'h5555_aaaa; the bench echoes `tx_req` as `tx_ack` after 7 clk. Required: `tx_data=32'h5555_aaaa` and `tx_req=1` two edges after accept; `tx_done` pulses once; `busy` drops to 0.
- Burst of 4 words, starting at 32'h5555_aaaa and incrementing by 32'h4321, with a 20 MHz-style receiver model (ack delay 5 to 8 clk). Required: `tx_req` toggles 4 times; `tx_data` sequence matches the input exactly; `ovf=0`.
- Burst of 6 words with ack withheld. Required: `din_rdy=0` after the 5th accepted word (4 in FIFO plus 1 in `tx_data`); 6th word dropped; `ovf=1` and it stays 1 after acks resume; exactly 5 words delivered.
- Slow receiver at 999 kHz ratio (ack about 100 clk after request). Required: `tx_data` is stable across every request interval; no duplicate `tx_done`.
- `rst` asserted during WAIT with 2 words queued. Required: next cycle shows `tx_req=0`, `tx_data=0`, `busy=0`, `din_rdy=1`; after a receiver reset, a new word transfers normally.
- Push and pop in the same cycle with count=2. Required: count stays 2 and FIFO order is preserved.

Source files
------------

// File: rtl/cdc_f2s_sender_pkg.sv
// Shared definitions for the fast-to-slow word sender: FSM encoding and default depth
// of the acknowledge synchronizer.
package cdc_f2s_sender_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_f2s_sender_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; a push is refused while full even if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdc_f2s_sender.sv
// Fast-domain sender: buffers input words and hands them one at a time to a slow domain
// over a held data bus with a toggle request / toggle acknowledge handshake.
module cdc_f2s_sender
  import cdc_f2s_sender_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  output logic          din_rdy,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          tx_ack,
  output logic          tx_done,
  output logic          busy,
  output logic          ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [DW-1:0]          r_tx_data;
  logic                   r_tx_req;
  logic                   r_tx_done;
  logic                   r_ovf;

  logic                   w_ack_s;
  logic                   w_pop;
  logic [DW-1:0]          w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (din_en),
    .din   (din),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // tx_ack is asynchronous; only the last synchronizer stage is ever used
  always_ff @(posedge clk) begin
    if (rst) r_ack_sync <= '0;
    else     r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], tx_ack};
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
  assign w_pop   = (r_state == S_LOAD);
  assign din_rdy = (w_fifo_count != CW'(DEPTH));
  assign busy    = ~w_fifo_empty | (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_tx_req  <= 1'b0;
      r_tx_done <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (din_en && w_fifo_full) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (!w_fifo_empty) r_state <= S_LOAD;
        // the only place tx_data/tx_req move, so the bus is frozen while a request is open
        S_LOAD: begin
          r_tx_data <= w_fifo_dout;
          r_tx_req  <= ~r_tx_req;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (w_ack_s == r_tx_req) begin
          r_tx_done <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data = r_tx_data;
  assign tx_req  = r_tx_req;
  assign tx_done = r_tx_done;
  assign ovf     = r_ovf;

endmodule
